ks_addsub_pipe: RTL and testbench

KS_ADDSUB_PIPE -- requirements
Module: ks_addsub_pipe

---
 rtl/ks_addsub_pipe_pkg.sv | 36 +++
 rtl/ks_addsub_pipe_if.sv | 29 ++
 rtl/ks_prefix_tree.sv | 48 ++++
 rtl/ks_addsub_pipe.sv | 99 +++++++++
 tb/tb_ks_addsub_pipe.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ks_addsub_pipe_pkg.sv
// Shared types and helpers for the Kogge-Stone add/sub pipeline.
// Width legality, prefix depth and prefix-cell primitives live here.
package ks_addsub_pipe_pkg;

  function automatic bit legal_width(int w);
    return (w == 4) || (w == 8) || (w == 16) || (w == 32);
  endfunction

  function automatic int levels(int w);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < w) n = i + 1;
    end
    return n;
  endfunction

  typedef struct packed {
    logic v1;
    logic v2;
    logic v3;
  } stage_valid_t;

  function automatic logic gray_cell(
    logic gh, logic ph, logic gl
  );
    return gh | (ph & gl);
  endfunction

  function automatic logic [1:0] black_cell(
    logic gh, logic ph, logic gl, logic pl
  );
    return {gh | (ph & gl), ph & pl};
  endfunction

endpackage

// File: rtl/ks_addsub_pipe_if.sv
// Operand/result handshake bundle for ks_addsub_pipe.
// master drives operands and out_ready; slave is the pipeline.
interface ks_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result,
    input  cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result,
    output cout, ovf, zero
  );
endinterface

// File: rtl/ks_prefix_tree.sv
// Combinational Kogge-Stone prefix tree with carry-in folded at bit 0.
// gg[i] is the group generate of bits i..0 including the carry-in.
module ks_prefix_tree
  import ks_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  input  logic             cin,
  output logic [WIDTH-1:0] gg
);

  localparam int L = levels(WIDTH);

  logic [WIDTH-1:0] gk [0:L];
  logic [WIDTH-1:0] pk [0:L];

  // Bits below 2*span are fully resolved at each level, so they only
  // need a gray cell; bit 1 borrows the freshly folded bit 0 at level 1.
  always_comb begin
    gk[0] = g;
    pk[0] = p;
    for (int l = 1; l <= L; l++) begin
      gk[l] = gk[l-1];
      pk[l] = pk[l-1];
      for (int i = 0; i < WIDTH; i++) begin
        if (l == 1 && i == 0) begin
          gk[1][0] = gray_cell(g[0], p[0], cin);
        end else if (l == 1 && i == 1) begin
          gk[1][1] = gray_cell(g[1], p[1], gk[1][0]);
        end else if (i >= (1 << (l-1))) begin
          if (l > 1 && i < (2 << (l-1))) begin
            gk[l][i] = gray_cell(gk[l-1][i], pk[l-1][i],
                                 gk[l-1][i-(1 << (l-1))]);
          end else begin
            {gk[l][i], pk[l][i]} =
              black_cell(gk[l-1][i], pk[l-1][i],
                         gk[l-1][i-(1 << (l-1))],
                         pk[l-1][i-(1 << (l-1))]);
          end
        end
      end
    end
    gg = gk[L];
  end

endmodule

// File: rtl/ks_addsub_pipe.sv
// Three-stage Kogge-Stone adder/subtractor with valid/ready flow control.
// S1: p/g + carry-in, S2: prefix generates, S3: result and flags.
module ks_addsub_pipe
  import ks_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  ks_addsub_pipe_if.slave bus
);

  if (!legal_width(WIDTH)) begin : g_bad_width
    $error("ks_addsub_pipe: WIDTH must be 4, 8, 16 or 32");
  end

  stage_valid_t v_q;
  logic ld1, ld2, ld3, acc;

  assign ld3 = !v_q.v3 || bus.out_ready;
  assign ld2 = !v_q.v2 || ld3;
  assign ld1 = !v_q.v1 || ld2;
  assign acc = bus.in_valid && ld1;

  assign bus.in_ready = ld1;

  logic [WIDTH-1:0] b_x, p_d, g_d;
  logic [WIDTH-1:0] p1_q, g1_q;
  logic             cin1_q;
  logic [WIDTH-1:0] gg_d;
  logic [WIDTH-1:0] p2_q, gg2_q;
  logic             cin2_q;

  assign b_x = bus.b ^ {WIDTH{bus.sub}};
  assign p_d = bus.a ^ b_x;
  assign g_d = bus.a & b_x;

  ks_prefix_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .p   (p1_q),
    .g   (g1_q),
    .cin (cin1_q),
    .gg  (gg_d)
  );

  logic [WIDTH-1:0] res_d, res_q;
  logic             cout_d, ovf_d, zero_d;
  logic             cout_q, ovf_q, zero_q;

  assign res_d  = p2_q ^ {gg2_q[WIDTH-2:0], cin2_q};
  assign cout_d = gg2_q[WIDTH-1];
  assign ovf_d  = gg2_q[WIDTH-2] ^ gg2_q[WIDTH-1];
  assign zero_d = ~|res_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      if (ld1) v_q.v1 <= acc;
      if (ld2) v_q.v2 <= v_q.v1;
      if (ld3) v_q.v3 <= v_q.v2;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      p1_q   <= p_d;
      g1_q   <= g_d;
      cin1_q <= bus.sub;
    end
    if (ld2 && v_q.v1) begin
      p2_q   <= p1_q;
      gg2_q  <= gg_d;
      cin2_q <= cin1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (ld3 && v_q.v2) begin
      res_q  <= res_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = v_q.v3;
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Directed bench for ks_addsub_pipe at WIDTH=16 plus a WIDTH=4 sweep.
// Each task drives a scenario and checks outputs inline.
module tb_ks_addsub_pipe;

  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;

  ks_addsub_pipe_if #(.WIDTH(16)) bus ();
  ks_addsub_pipe_if #(.WIDTH(4))  bus4 ();

  ks_addsub_pipe #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ks_addsub_pipe #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  function automatic exp_t model16(
    logic [15:0] a, logic [15:0] b, logic sub
  );
    logic [15:0] bb;
    logic [16:0] s;
    exp_t e;
    bb = sub ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + 17'(sub);
    e.res  = s[15:0];
    e.cout = s[16];
    e.ovf  = (a[15] == bb[15]) && (s[15] != a[15]);
    e.zero = (s[15:0] == 16'h0);
    return e;
  endfunction

  function automatic exp_t got16();
    exp_t e;
    e.res  = bus.result;
    e.cout = bus.cout;
    e.ovf  = bus.ovf;
    e.zero = bus.zero;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h0001;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    vectors++;
    if ({bus.result, bus.cout, bus.ovf, bus.zero} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h/%b%b%b want 0",
               bus.result, bus.cout, bus.ovf, bus.zero);
    end
    vectors++;
    if (bus4.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_w4_valid got %b want 0", bus4.out_valid);
    end
  endtask

  task automatic test_latency();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'h0005;
    bus.b = 16'h0003;
    bus.sub = 1'b1;
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_edge1 got %b want 0", bus.out_valid);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_edge2 got %b want 0", bus.out_valid);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lat_edge3 got %b want 1", bus.out_valid);
    end
    vectors++;
    if (got16() !== {16'h0002, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL lat_5m3 got %h want 0002/100", got16());
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_drop got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'h0003;
    bus.b = 16'h0005;
    bus.sub = 1'b1;
    step();
    bus.a = 16'h7FFF;
    bus.b = 16'h0001;
    bus.sub = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    vectors++;
    if (!bus.out_valid || got16() !== {16'hFFFE, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_3m5 got v=%b %h want 1 FFFE/000",
               bus.out_valid, got16());
    end
    step();
    vectors++;
    if (!bus.out_valid || got16() !== {16'h8000, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_ovf got v=%b %h want 1 8000/010",
               bus.out_valid, got16());
    end
  endtask

  task automatic test_zero();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'hA5A5;
    bus.b = 16'hA5A5;
    bus.sub = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (2) step();
    vectors++;
    if (!bus.out_valid || got16() !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL zero_flag got v=%b %h want 1 0000/101",
               bus.out_valid, got16());
    end
  endtask

  task automatic test_stall();
    exp_t q[$];
    exp_t held, e;
    logic held_v;
    int sent, got;
    sent = 0;
    got = 0;
    held_v = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 8);
      bus.in_valid = (sent < 10);
      bus.a = 16'(sent * 4099 + 7);
      bus.b = 16'(sent * 257 + 3);
      bus.sub = sent[0];
      #1;
      if (cyc == 6) begin
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_full got rdy=%b v=%b want 0 1",
                   bus.in_ready, bus.out_valid);
        end
      end
      if (cyc == 9) begin
        vectors++;
        if (bus.in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_release got %b want 1", bus.in_ready);
        end
      end
      if (held_v) begin
        vectors++;
        if (got16() !== held || bus.out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold got %h want %h", got16(), held);
        end
      end
      held_v = bus.out_valid && !bus.out_ready;
      held = got16();
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL stall_extra got %h want none", got16());
        end else begin
          e = q.pop_front();
          if (got16() !== e) begin
            miscompares++;
            $display("FAIL stall_data got %h want %h", got16(), e);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model16(bus.a, bus.b, bus.sub));
        sent++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (got != 10) begin
      miscompares++;
      $display("FAIL stall_count got %0d want 10", got);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.sub = 1'b0;
    step();
    bus.a = 16'h3333;
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.result !== 16'h0) begin
      miscompares++;
      $display("FAIL rstmid_state got rdy=%b res=%h want 1 0000",
               bus.in_ready, bus.result);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_leak got %b want 0 at %0d",
                 bus.out_valid, i);
      end
      step();
    end
    bus.in_valid = 1'b1;
    bus.a = 16'h0009;
    bus.b = 16'h0004;
    bus.sub = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_early got %b want 0", bus.out_valid);
    end
    step();
    vectors++;
    if (!bus.out_valid || got16() !== {16'h000D, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_after got v=%b %h want 1 000D/000",
               bus.out_valid, got16());
    end
  endtask

  task automatic test_mixed();
    logic [15:0] ta [8];
    logic [15:0] tb [8];
    logic        ts [8];
    exp_t        te [8];
    int sent, got;
    ta = '{16'hFFFF, 16'h8000, 16'h8000, 16'h1234,
           16'h0000, 16'h7FFF, 16'hAAAA, 16'hFFFF};
    tb = '{16'h0001, 16'h0001, 16'h8000, 16'h4321,
           16'h0001, 16'hFFFF, 16'h5555, 16'h8000};
    ts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    te = '{{16'h0000, 3'b101}, {16'h7FFF, 3'b110},
           {16'h0000, 3'b111}, {16'h5555, 3'b000},
           {16'hFFFF, 3'b000}, {16'h8000, 3'b010},
           {16'hFFFF, 3'b000}, {16'h7FFF, 3'b100}};
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      bus.out_ready = (cyc % 3 != 2);
      bus.in_valid = (sent < 8);
      bus.a = ta[sent % 8];
      bus.b = tb[sent % 8];
      bus.sub = ts[sent % 8];
      #1;
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (got16() !== te[got % 8]) begin
          miscompares++;
          $display("FAIL mixed_%0d got %h want %h",
                   got, got16(), te[got % 8]);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL mixed_count got %0d want 8", got);
    end
  endtask

  task automatic test_width4();
    logic [6:0] q4[$];
    logic [6:0] e;
    logic [3:0] bb;
    logic [4:0] s;
    int n, got;
    n = 0;
    got = 0;
    for (int cyc = 0; cyc < 1200 && got < 512; cyc++) begin
      bus4.out_ready = (cyc % 7 != 3);
      bus4.in_valid = (n < 512);
      {bus4.sub, bus4.a, bus4.b} = 9'(n);
      #1;
      if (bus4.out_valid && bus4.out_ready) begin
        vectors++;
        if (q4.size() == 0) begin
          miscompares++;
          $display("FAIL w4_extra got %h want none", bus4.result);
        end else begin
          e = q4.pop_front();
          if ({bus4.result, bus4.cout, bus4.ovf, bus4.zero} !== e) begin
            miscompares++;
            $display("FAIL w4_data got %h/%b%b%b want %h",
                     bus4.result, bus4.cout, bus4.ovf, bus4.zero, e);
          end
        end
        got++;
      end
      if (bus4.in_valid && bus4.in_ready) begin
        bb = bus4.sub ? ~bus4.b : bus4.b;
        s = {1'b0, bus4.a} + {1'b0, bb} + 5'(bus4.sub);
        q4.push_back({s[3:0], s[4],
                      (bus4.a[3] == bb[3]) && (s[3] != bus4.a[3]),
                      s[3:0] == 4'h0});
        n++;
      end
      step();
    end
    bus4.in_valid = 1'b0;
    vectors++;
    if (got != 512) begin
      miscompares++;
      $display("FAIL w4_count got %0d want 512", got);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.sub = 1'b0;
    bus4.out_ready = 1'b1;
    test_reset();
    idle();
    test_latency();
    idle();
    test_back_to_back();
    idle();
    test_zero();
    idle();
    test_stall();
    idle();
    test_reset_mid();
    idle();
    test_mixed();
    idle();
    test_width4();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
